inst_axi_bridge: RTL

INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

---
 rtl/inst_axi_bridge_if.sv | 43 ++++
 rtl/inst_axi_bridge.sv | 92 +++++++++
 2 files changed

// File: rtl/inst_axi_bridge_if.sv
// Fetch-side request/response and AXI read-channel signals of the instruction bridge.
// master: the bridge itself; slave: its environment (fetch stage plus AXI memory).
interface inst_axi_bridge_if;
  logic        if_valid;
  logic [1:0]  if_size;
  logic [63:0] inst_addr;
  logic        if_ready;
  logic [1:0]  if_resp;
  logic [63:0] if_data_read;

  logic        axi_ar_ready_i;
  logic        axi_ar_valid_o;
  logic [63:0] axi_ar_addr_o;
  logic [3:0]  axi_ar_id_o;
  logic [7:0]  axi_ar_len_o;
  logic [2:0]  axi_ar_size_o;
  logic [1:0]  axi_ar_burst_o;

  logic        axi_r_ready_o;
  logic        axi_r_valid_i;
  logic [1:0]  axi_r_resp_i;
  logic [63:0] axi_r_data_i;
  logic        axi_r_last_i;
  logic [3:0]  axi_r_id_i;

  modport master (
    input  if_valid, if_size, inst_addr,
    output if_ready, if_resp, if_data_read,
    input  axi_ar_ready_i,
    output axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
    output axi_r_ready_o,
    input  axi_r_valid_i, axi_r_resp_i, axi_r_data_i, axi_r_last_i, axi_r_id_i
  );

  modport slave (
    output if_valid, if_size, inst_addr,
    input  if_ready, if_resp, if_data_read,
    output axi_ar_ready_i,
    input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
    input  axi_r_ready_o,
    output axi_r_valid_i, axi_r_resp_i, axi_r_data_i, axi_r_last_i, axi_r_id_i
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// Single-outstanding instruction fetch bridge: one 64-bit AXI read per fetch,
// returning the addressed 32-bit instruction word in the low half.
module inst_axi_bridge #(
  parameter logic [3:0] AXI_ID    = 4'd0,
  parameter logic [1:0] RESP_OKAY = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  inst_axi_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  size;
  } fetch_req_t;

  state_t     state;
  fetch_req_t req_q;
  logic       abort_q;
  logic       beat_ok;
  logic       deliver;
  logic       unused_req;

  // Single-beat INCR reads of a full 64-bit doubleword.
  assign bus.axi_ar_id_o    = AXI_ID;
  assign bus.axi_ar_len_o   = 8'd0;
  assign bus.axi_ar_size_o  = 3'b011;
  assign bus.axi_ar_burst_o = 2'b01;

  assign beat_ok = bus.axi_r_valid_i && bus.axi_r_last_i && (bus.axi_r_id_i == AXI_ID);
  // A fetch withdrawn at any point while on the bus is finished silently.
  assign deliver = !abort_q && bus.if_valid;

  // Only addr[2] is needed after the AR phase; the rest is kept for debug visibility.
  assign unused_req = ^{req_q.size, req_q.addr[63:3], req_q.addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      req_q              <= '0;
      abort_q            <= 1'b0;
      bus.if_ready       <= 1'b0;
      bus.if_resp        <= RESP_OKAY;
      bus.if_data_read   <= '0;
      bus.axi_ar_valid_o <= 1'b0;
      bus.axi_ar_addr_o  <= '0;
      bus.axi_r_ready_o  <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_valid) begin
            req_q              <= '{addr: bus.inst_addr, size: bus.if_size};
            abort_q            <= 1'b0;
            bus.axi_ar_addr_o  <= {bus.inst_addr[63:3], 3'b000};
            bus.axi_ar_valid_o <= 1'b1;
            state              <= AR;
          end
        end
        AR: begin
          if (!bus.if_valid) abort_q <= 1'b1;
          if (bus.axi_ar_ready_i) begin
            bus.axi_ar_valid_o <= 1'b0;
            bus.axi_r_ready_o  <= 1'b1;
            state              <= R;
          end
        end
        R: begin
          if (!bus.if_valid) abort_q <= 1'b1;
          // Beats for other IDs are accepted (rready stays high) and dropped.
          if (beat_ok) begin
            bus.axi_r_ready_o <= 1'b0;
            if (deliver) begin
              bus.if_data_read <= {bus.axi_r_data_i[63:32],
                                   req_q.addr[2] ? bus.axi_r_data_i[63:32] : bus.axi_r_data_i[31:0]};
              bus.if_resp      <= bus.axi_r_resp_i;
              bus.if_ready     <= 1'b1;
              state            <= DONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
